// File: rtl/regfile_scan_checker.sv
// rtl/regfile_scan_checker.sv - run-then-scan regfile checker against an expected-value memory
// Hijacks read port A after a programmed run length and counts masked mismatches.
module regfile_scan_checker #(
  parameter int                  NUM_REGS   = 32,
  parameter int                  REG_AW     = 5,
  parameter int                  DATA_W     = 32,
  parameter int                  CYC_W      = 16,
  parameter logic [NUM_REGS-1:0] CHECK_MASK = {NUM_REGS{1'b1}}
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CYC_W-1:0]  num_cycles,
  input  logic              stop_on_fail,
  output logic              test_mode,
  output logic [REG_AW-1:0] test_reg,
  input  logic [DATA_W-1:0] reg_data,
  output logic [REG_AW-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [REG_AW:0]   error_count,
  output logic              first_fail_valid,
  output logic [REG_AW-1:0] first_fail_reg,
  output logic [CYC_W-1:0]  cycle_count
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_SCAN, S_DRAIN, S_DONE} state_t;

  localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(NUM_REGS - 1);
  localparam logic [REG_AW-1:0] IDX_ONE  = REG_AW'(1);
  localparam logic [CYC_W-1:0]  CYC_ONE  = CYC_W'(1);
  localparam logic [REG_AW:0]   ERR_ONE  = (REG_AW + 1)'(1);

  state_t              state, state_nx;
  logic [REG_AW-1:0]   idx;
  logic [CYC_W-1:0]    n_lat;
  logic                sof_lat;
  logic                pipe_valid;
  logic [DATA_W-1:0]   pipe_data;
  logic [REG_AW-1:0]   pipe_idx;
  logic                pipe_mask;
  logic                start_ok;
  logic                mismatch;
  logic                stop_now;
  logic [REG_AW:0]     err_nx;

  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
  assign mismatch = pipe_valid && pipe_mask && (pipe_data != exp_data);
  assign stop_now = mismatch && sof_lat;
  assign err_nx   = (mismatch && !(&error_count)) ? error_count + ERR_ONE : error_count;
  assign test_reg = idx;
  assign exp_addr = idx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start_ok) state_nx = (num_cycles == '0) ? S_SCAN : S_RUN;
      S_RUN:          if (cycle_count == n_lat - CYC_ONE) state_nx = S_SCAN;
      S_SCAN: begin
        if (stop_now)              state_nx = S_DONE;
        else if (idx == LAST_IDX)  state_nx = S_DRAIN;
      end
      S_DRAIN:        state_nx = S_DONE;
      default:        state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    test_mode = (state == S_SCAN) || (state == S_DRAIN);
    busy      = (state == S_RUN) || (state == S_SCAN) || (state == S_DRAIN);
    done      = (state == S_DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx              <= '0;
      n_lat            <= '0;
      sof_lat          <= 1'b0;
      pipe_valid       <= 1'b0;
      pipe_data        <= '0;
      pipe_idx         <= '0;
      pipe_mask        <= 1'b0;
      pass             <= 1'b0;
      error_count      <= '0;
      first_fail_valid <= 1'b0;
      first_fail_reg   <= '0;
      cycle_count      <= '0;
    end else begin
      // A stop-on-fail exit drops whatever register is being captured on the same edge.
      pipe_valid <= (state == S_SCAN) && !stop_now;
      pipe_data  <= reg_data;
      pipe_idx   <= idx;
      pipe_mask  <= CHECK_MASK[idx];

      error_count <= err_nx;
      if (mismatch && !first_fail_valid) begin
        first_fail_valid <= 1'b1;
        first_fail_reg   <= pipe_idx;
      end

      if (state == S_RUN) cycle_count <= cycle_count + CYC_ONE;
      if (state == S_SCAN && idx != LAST_IDX) idx <= idx + IDX_ONE;

      if (state_nx == S_DONE && state != S_DONE) pass <= (err_nx == '0);

      if (start_ok) begin
        n_lat            <= num_cycles;
        sof_lat          <= stop_on_fail;
        idx              <= '0;
        pass             <= 1'b0;
        error_count      <= '0;
        first_fail_valid <= 1'b0;
        first_fail_reg   <= '0;
        cycle_count      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scan_checker.sv
// tb/tb_regfile_scan_checker.sv - scoreboard bench for regfile_scan_checker
// Two instances share stimulus; the second has compare-mask bit 7 cleared.
module tb_regfile_scan_checker;

  typedef struct {
    logic        pass;
    logic [5:0]  err;
    logic        ffv;
    logic [4:0]  ffr;
    logic [15:0] cc;
    int          lat;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] num_cycles;
  logic        stop_on_fail;

  logic        test_mode_a, busy_a, done_a, pass_a, ffv_a;
  logic [4:0]  test_reg_a, exp_addr_a, ffr_a;
  logic [31:0] reg_data_a, exp_data_a;
  logic [5:0]  err_a;
  logic [15:0] cc_a;

  logic        test_mode_b, busy_b, done_b, pass_b, ffv_b;
  logic [4:0]  test_reg_b, exp_addr_b, ffr_b;
  logic [31:0] reg_data_b, exp_data_b;
  logic [5:0]  err_b;
  logic [15:0] cc_b;

  logic [31:0] rf [32];
  logic [31:0] em [32];

  exp_t q_a[$];
  exp_t q_b[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  logic done_a_d = 1'b0;
  logic done_b_d = 1'b0;

  regfile_scan_checker dut_a (
    .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
    .stop_on_fail(stop_on_fail), .test_mode(test_mode_a), .test_reg(test_reg_a),
    .reg_data(reg_data_a), .exp_addr(exp_addr_a), .exp_data(exp_data_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .error_count(err_a),
    .first_fail_valid(ffv_a), .first_fail_reg(ffr_a), .cycle_count(cc_a)
  );

  regfile_scan_checker #(.CHECK_MASK(32'hFFFF_FF7F)) dut_b (
    .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
    .stop_on_fail(stop_on_fail), .test_mode(test_mode_b), .test_reg(test_reg_b),
    .reg_data(reg_data_b), .exp_addr(exp_addr_b), .exp_data(exp_data_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .error_count(err_b),
    .first_fail_valid(ffv_b), .first_fail_reg(ffr_b), .cycle_count(cc_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign reg_data_a = rf[test_reg_a];
  assign reg_data_b = rf[test_reg_b];
  always @(posedge clock) begin
    exp_data_a <= em[exp_addr_a];
    exp_data_b <= em[exp_addr_b];
    cyc <= cyc + 1;
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(logic p, int e, logic fv, int fr, int c, int l);
    exp_t r;
    r.pass = p; r.err = 6'(e); r.ffv = fv; r.ffr = 5'(fr); r.cc = 16'(c); r.lat = l;
    return r;
  endfunction

  task automatic compare_result(string tag, exp_t e, logic p, logic [5:0] er, logic fv,
                                logic [4:0] fr, logic [15:0] c, int lat);
    check({tag, "_latency"}, lat, e.lat);
    check({tag, "_pass"}, p, e.pass);
    check({tag, "_error_count"}, er, e.err);
    check({tag, "_ff_valid"}, fv, e.ffv);
    check({tag, "_ff_reg"}, fr, e.ffr);
    check({tag, "_cycle_count"}, c, e.cc);
  endtask

  // Monitor: every rising done pops one expected result per instance.
  always @(negedge clock) begin
    exp_t e;
    if (done_a && !done_a_d) begin
      if (q_a.size() == 0) check("a_unexpected_done", 1, 0);
      else begin
        e = q_a.pop_front();
        compare_result("a", e, pass_a, err_a, ffv_a, ffr_a, cc_a, cyc - accept_cyc);
      end
    end
    if (done_b && !done_b_d) begin
      if (q_b.size() == 0) check("b_unexpected_done", 1, 0);
      else begin
        e = q_b.pop_front();
        compare_result("b", e, pass_b, err_b, ffv_b, ffr_b, cc_b, cyc - accept_cyc);
      end
    end
    done_a_d = done_a;
    done_b_d = done_b;
  end

  task automatic init_data();
    for (int i = 0; i < 32; i++) begin
      rf[i] = 32'(i * 3);
      em[i] = 32'(i * 3);
    end
  endtask

  task automatic run(int n, logic sof, exp_t ea, exp_t eb, int busy_start_at);
    int t;
    q_a.push_back(ea);
    q_b.push_back(eb);
    @(negedge clock);
    num_cycles = 16'(n); stop_on_fail = sof; start = 1'b1;
    @(negedge clock);
    start = 1'b0; accept_cyc = cyc;
    if (n > 0) begin
      for (int k = 1; k < n; k++) @(negedge clock);
      check("test_mode_before_scan", test_mode_a, 0);
      @(negedge clock);
    end
    check("test_mode_at_scan", test_mode_a, 1);
    t = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && t < 200) begin
      @(negedge clock);
      t++;
      if (t == busy_start_at) begin
        num_cycles = 16'd7; stop_on_fail = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check("done_within_budget", t < 200, 1);
    q_a.delete();
    q_b.delete();
  endtask

  initial begin
    int t;
    reset = 1'b0; start = 1'b0; num_cycles = '0; stop_on_fail = 1'b0;
    init_data();
    repeat (3) @(negedge clock);
    check("reset_outputs", {test_mode_a, test_reg_a, exp_addr_a, busy_a, done_a, pass_a,
                            err_a, ffv_a, ffr_a, cc_a}, 0);
    reset = 1'b1;
    @(negedge clock);

    // All match, N=20
    run(20, 1'b0, mk(1, 0, 0, 0, 20, 53), mk(1, 0, 0, 0, 20, 53), 0);

    // Mismatches at r7 and r30; instance b ignores r7
    init_data(); em[7] ^= 32'h1; em[30] ^= 32'h100;
    run(5, 1'b0, mk(0, 2, 1, 7, 5, 38), mk(0, 1, 1, 30, 5, 38), 0);

    // Stop on first fail at r3; r10 must not be counted
    init_data(); em[3] ^= 32'h4; em[10] ^= 32'h1;
    run(5, 1'b1, mk(0, 1, 1, 3, 5, 10), mk(0, 1, 1, 3, 5, 10), 0);

    // Last register mismatches in DRAIN with stop_on_fail set
    init_data(); em[31] ^= 32'h8000_0000;
    run(3, 1'b1, mk(0, 1, 1, 31, 3, 36), mk(0, 1, 1, 31, 3, 36), 0);

    // N=0 with an ignored start while busy, then restart from DONE
    init_data(); em[20] ^= 32'h2;
    run(0, 1'b0, mk(0, 1, 1, 20, 0, 33), mk(0, 1, 1, 20, 0, 33), 10);
    init_data();
    run(0, 1'b0, mk(1, 0, 0, 0, 0, 33), mk(1, 0, 0, 0, 0, 33), 0);

    // Reset mid-scan at index 9 after an error has been counted
    init_data(); em[2] ^= 32'h1;
    @(negedge clock);
    num_cycles = 16'd0; stop_on_fail = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    t = 0;
    while (!(test_mode_a && test_reg_a == 5'd9) && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("reach_index9", t < 100, 1);
    check("err_before_reset", err_a, 1);
    reset = 1'b0;
    #1;
    check("rst_mid_test_mode", test_mode_a, 0);
    check("rst_mid_error_count", err_a, 0);
    check("rst_mid_done", done_a, 0);
    check("rst_mid_busy", busy_a, 0);
    @(negedge clock);
    check("rst_mid_next_cycle", {test_mode_a, busy_a, done_a, err_a, ffv_a, test_reg_a}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_after_reset", {busy_a, done_a, test_mode_a}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_scan_checker.md
Name: regfile_scan_checker

Overview:
- Hardware version of the regfile self-check harness. It is parametrised in register count, data width and run length, and adds a compare mask and a stop-on-first-fail mode.
- It lets the processor run for a programmed number of cycles, then takes over the regfile read port A. It scans every register against an expected-value memory, counts mismatches, and reports pass/fail.
- It sits beside the processor/regfile in the board-level wrapper and drives the rs1 hijack mux.

Parameters:
- NUM_REGS, 32, number of registers scanned (indices 0..NUM_REGS-1).
- REG_AW, 5, register index width; 2^REG_AW >= NUM_REGS.
- DATA_W, 32, register/expected data width.
- CYC_W, 16, width of the run-length counter.
- CHECK_MASK, {NUM_REGS{1'b1}}, bit i=1 means register i is compared; bit i=0 means it is read but never counted.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  single-cycle request to begin run+scan; accepted only in IDLE or DONE.
- num_cycles  in  CYC_W  processor run length, latched on start accept.
- stop_on_fail  in  1  latched on start accept; 1 = end the scan at the first mismatch.
- test_mode  out  1  1 while scanning; selects test_reg onto the regfile read port A.
- test_reg  out  REG_AW  register index presented to the regfile during scan.
- reg_data  in  DATA_W  regfile read port A data; combinational, valid in the same cycle as test_reg.
- exp_addr  out  REG_AW  expected-memory address.
- exp_data  in  DATA_W  expected-memory data; synchronous, valid one cycle after exp_addr.
- busy  out  1  high in RUN, SCAN and DRAIN.
- done  out  1  high in DONE.
- pass  out  1  valid when done; 1 iff error_count==0.
- error_count  out  REG_AW+1  number of mismatches; saturates at all-ones.
- first_fail_valid  out  1  a mismatch has been captured.
- first_fail_reg  out  REG_AW  index of the first mismatching register.
- cycle_count  out  CYC_W  processor cycles elapsed in RUN.

Behaviour:
- Reset (async, reset==0): state=IDLE. All outputs 0: test_mode, test_reg, exp_addr, busy, done, pass, error_count, first_fail_valid, first_fail_reg, cycle_count. The pipeline register is cleared.
- States: IDLE, RUN, SCAN, DRAIN, DONE.
- Start accept (IDLE or DONE, start==1):
  - Latch num_cycles and stop_on_fail.
  - Clear error_count, first_fail_*, cycle_count and pass.
  - Go to RUN; if num_cycles==0, go directly to SCAN with index 0.
  - start is ignored while busy.
- RUN:
  - test_mode=0.
  - cycle_count increments each edge.
  - On the edge where cycle_count==N-1, go to SCAN with index=0. RUN therefore occupies exactly N cycles.
- SCAN:
  - test_mode=1; test_reg=exp_addr=index.
  - Each edge: capture {reg_data, index, CHECK_MASK[index]} into a one-stage pipeline register, then index++.
  - On the edge where index==NUM_REGS-1, go to DRAIN. SCAN occupies NUM_REGS cycles.
- Compare stage (every cycle the pipeline stage is valid, in SCAN or DRAIN):
  - If the mask bit is set and the captured data != exp_data, it is a mismatch.
  - Mismatch: error_count++ with saturation. If first_fail_valid==0, set first_fail_valid=1 and first_fail_reg=captured index.
- DRAIN:
  - test_mode=1 (holds the last index).
  - The compare for the final register occurs here.
  - Next state is DONE.
- stop_on_fail=1: on the first mismatch, go to DONE on that edge. Any in-flight capture is discarded, so error_count ends at 1.
- DONE:
  - done=1; test_mode=0; pass=(error_count==0).
  - Outputs hold until start or reset.
- Latency with stop_on_fail=0: start-accept edge to done high is N+NUM_REGS+1 cycles.
- Reset mid-operation: immediate return to IDLE; no partial results retained.
- Boundaries:
  - index wraps are never exercised; the scan ends before index reaches NUM_REGS.
  - error_count saturates and does not wrap.
  - A simultaneous mismatch and last compare in DRAIN both count, then the block enters DONE.

Test Plan:
- Reset asserted mid-SCAN at index 9 -> next cycle: state IDLE, test_mode=0, error_count=0, done=0.
- N=20, all 32 regs match (r0=0, ri=i*3), mask all-ones -> test_mode rises at cycle 20; done at cycle 53; pass=1; error_count=0; cycle_count=20.
- N=5, exp mismatch at r7 and r30 -> error_count=2, first_fail_valid=1, first_fail_reg=7, pass=0.
- Same as previous, with CHECK_MASK bit 7 cleared -> error_count=1, first_fail_reg=30.
- stop_on_fail=1, mismatch at r3 -> done one cycle after r3's compare; error_count=1; first_fail_reg=3; later mismatches not counted.
- num_cycles=0, start pulsed while busy, then start again in DONE -> first run skips RUN (done after 33 cycles); mid-run start ignored; restart clears counters and reruns.
